// File: rtl/pack_stream.sv
// pack_stream: streaming lane packer.
//
// Each accepted input beat has its valid lanes (in_msk) compacted toward lane 0.
// The compacted lanes are appended to a residual buffer of up to N-1 lanes.
// Only dense N-lane beats are emitted, except at frame end (in_last) or on an
// optional idle timeout, where a partial beat is flushed. A frame end that
// leaves more than N lanes pending takes one extra FLUSH cycle to drain the
// remainder.
//
// Optional feature: define PACK_STREAM_TIMEOUT_EN to flush the residual after
// TIMEOUT idle cycles. When it is undefined, the residual is held until the
// frame is completed or ended by in_last.
//
// Parameters:
//   N       lane count per beat (power of two, >= 2)
//   W       lane data width
//   TIMEOUT idle cycles before a residual flush (timeout build only)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_vld/in_rdy               input handshake; in_rdy does not depend on in_vld
//   in_last                     final beat of frame
//   in_w, in_msk                lane data and per-lane valid
//   out_vld_r/out_rdy           registered output valid, consumer ready
//   out_r                       packed lanes; lanes at or above the count read 0
//   out_msk_r                   contiguous unary mask of valid lanes
//   out_last_r                  frame end on this beat
module pack_stream #(
  parameter int unsigned N       = 8,
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic                in_last,
  input  logic [N-1:0][W-1:0] in_w,
  input  logic [N-1:0]        in_msk,
  output logic                out_vld_r,
  input  logic                out_rdy,
  output logic [N-1:0][W-1:0] out_r,
  output logic [N-1:0]        out_msk_r,
  output logic                out_last_r
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] NC = CW'(N);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("pack_stream: N must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("pack_stream: TIMEOUT must be >= 1");
  end

  typedef enum logic [0:0] {StAccum, StFlush} state_e;

  state_e                r_state;
  logic [N-2:0][W-1:0]   r_res;
  logic [CW-1:0]         r_cnt;
  logic                  r_out_vld;
  logic [N-1:0][W-1:0]   r_out;
  logic [N-1:0]          r_out_msk;
  logic                  r_out_last;

  state_e                w_state_nxt;
  logic [N-2:0][W-1:0]   w_res_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [N-1:0][W-1:0]   w_packed;
  logic [CW-1:0]         w_k;
  logic [2*N-1:0][W-1:0] w_cat;
  logic [CW-1:0]         w_tot;
  logic                  w_slot_free;
  logic                  w_acc;
  logic                  w_tmo_fire;
  logic                  w_emit;
  logic [CW-1:0]         w_emit_cnt;
  logic                  w_emit_last;
  logic [N-1:0][W-1:0]   w_emit_dat;
  logic [N-1:0]          w_out_msk_nxt;
  logic [N-1:0][W-1:0]   w_out_nxt;

  function automatic logic [N-1:0] unary(input logic [CW-1:0] c);
    return ~({N{1'b1}} << c);
  endfunction

  assign w_slot_free = !r_out_vld || out_rdy;
  // Held low during reset so no beat is taken while state is being cleared.
  assign in_rdy      = rst_n && (r_state == StAccum) && w_slot_free;
  assign w_acc       = in_vld && in_rdy;

  // Compaction: lane j lands at popcount(in_msk[j-1:0]).
  always_comb begin
    w_packed = '0;
    w_k      = '0;
    for (int j = 0; j < N; j++) begin
      if (in_msk[j]) begin
        w_packed[w_k[CW-2:0]] = in_w[j];
        w_k                   = w_k + CW'(1);
      end
    end
  end

  // Residual lanes followed by packed lanes; unused positions stay zero.
  always_comb begin
    w_cat = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (CW'(i) < r_cnt) w_cat[i] = r_res[i];
    end
    for (int p = 0; p < N; p++) begin
      if (CW'(p) < w_k) w_cat[r_cnt + CW'(p)] = w_packed[p];
    end
  end

  assign w_tot = r_cnt + w_k;

`ifdef PACK_STREAM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 2);

  logic [TW-1:0] r_tmo;

  assign w_tmo_fire = (r_state == StAccum) && (r_cnt != '0) && (r_tmo == TW'(TIMEOUT)) &&
                      w_slot_free && !w_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (w_acc || w_tmo_fire || (r_state != StAccum) || (r_cnt == '0)) begin
      r_tmo <= '0;
    end else if (r_tmo != TW'(TIMEOUT)) begin
      // Saturates while the output slot is blocked.
      r_tmo <= r_tmo + TW'(1);
    end
  end
`else
  assign w_tmo_fire = 1'b0;
`endif

  // Next-state and emit decision.
  always_comb begin
    w_state_nxt = r_state;
    w_res_nxt   = r_res;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_emit_cnt  = '0;
    w_emit_last = 1'b0;
    w_emit_dat  = '0;
    case (r_state)
      StAccum: begin
        if (w_acc) begin
          if (w_tot >= NC) begin
            w_emit     = 1'b1;
            w_emit_cnt = NC;
            for (int i = 0; i < N; i++) w_emit_dat[i] = w_cat[i];
            for (int i = 0; i < N - 1; i++) w_res_nxt[i] = w_cat[N+i];
            w_cnt_nxt = w_tot - NC;
            if (in_last) begin
              // Exactly N lanes close the frame here; more need a FLUSH beat.
              if (w_tot == NC) w_emit_last = 1'b1;
              else             w_state_nxt = StFlush;
            end
          end else if (in_last) begin
            // Includes t == 0: an empty last beat keeps the frame boundary.
            w_emit      = 1'b1;
            w_emit_cnt  = w_tot;
            w_emit_last = 1'b1;
            for (int i = 0; i < N; i++) w_emit_dat[i] = w_cat[i];
            w_res_nxt = '0;
            w_cnt_nxt = '0;
          end else begin
            for (int i = 0; i < N - 1; i++) w_res_nxt[i] = w_cat[i];
            w_cnt_nxt = w_tot;
          end
        end else if (w_tmo_fire) begin
          w_emit     = 1'b1;
          w_emit_cnt = r_cnt;
          for (int i = 0; i < N - 1; i++) w_emit_dat[i] = r_res[i];
          w_res_nxt = '0;
          w_cnt_nxt = '0;
        end
      end
      StFlush: begin
        if (w_slot_free) begin
          w_emit      = 1'b1;
          w_emit_cnt  = r_cnt;
          w_emit_last = 1'b1;
          for (int i = 0; i < N - 1; i++) w_emit_dat[i] = r_res[i];
          w_res_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = StAccum;
        end
      end
      default: begin
        w_state_nxt = StAccum;
        w_res_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Lanes outside the count are forced to zero.
  always_comb begin
    w_out_msk_nxt = unary(w_emit_cnt);
    w_out_nxt     = '0;
    for (int i = 0; i < N; i++) begin
      if (w_out_msk_nxt[i]) w_out_nxt[i] = w_emit_dat[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StAccum;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_res   <= w_res_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Emission only happens with the slot free, so a stalled beat is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out      <= '0;
      r_out_msk  <= '0;
      r_out_last <= 1'b0;
    end else if (w_emit) begin
      r_out_vld  <= 1'b1;
      r_out      <= w_out_nxt;
      r_out_msk  <= w_out_msk_nxt;
      r_out_last <= w_emit_last;
    end else if (w_slot_free) begin
      r_out_vld  <= 1'b0;
    end
  end

  assign out_vld_r  = r_out_vld;
  assign out_r      = r_out;
  assign out_msk_r  = r_out_msk;
  assign out_last_r = r_out_last;

endmodule
